div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative RV32M divider for DIV, DIVU, REM and REMU, placed between the register file read ports and the writeback path.
- Takes rs1/rs2 operand data plus the destination address and runs a restoring division at 1 bit per cycle.
- Presents the result to the writeback mux with a valid/ready handshake; the mux then drives the register file write port.

Parameters:
XLEN, 32, operand/result width; also the iteration count of the divide loop.

Ports:
i_clk  input  1  clock
i_rst  input  1  reset; asynchronous and active-low
i_valid  input  1  request valid
o_ready  output  1  unit can accept a request (state IDLE)
i_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
i_rs1_data  input  XLEN  dividend
i_rs2_data  input  XLEN  divisor
i_rd_addr  input  5  destination register
i_flush  input  1  synchronous abort (pipeline flush)
o_valid  output  1  result valid
i_wb_ready  input  1  writeback accepts the result this cycle
o_rd_addr  output  5  destination register of the result
o_rd_data  output  XLEN  quotient or remainder
o_busy  output  1  state != IDLE

Behaviour:
- Reset (i_rst low, async): state IDLE, o_valid=0, o_rd_addr=0, o_rd_data=0, o_busy=0, internal registers 0. o_ready=1 once reset is released. Reset during DIV or DONE drops the operation; no result is produced.
- Accept: i_valid && o_ready && !i_flush at edge T latches op, rd and operands.
- Signed ops: take operand magnitudes; quotient sign = sign1 XOR sign2; remainder sign = sign of dividend. Unsigned ops use operands as-is.
- States:
  - IDLE -> DIV on accept (normal path).
  - IDLE -> DONE on accept (fast path, see special cases).
  - DIV: 32 iterations in cycles T+1..T+32, counter 0..31. Each cycle shift {rem,quo} left 1, subtract divisor; if no borrow, keep the difference and set quo bit. After iteration 31, apply sign correction -> DONE.
  - DONE: o_valid=1 with o_rd_data/o_rd_addr held stable. On i_wb_ready -> IDLE at next edge.
- Latency (normal): o_valid first high in cycle T+33. o_ready returns the cycle after the handshake.
- Special cases (fast path, o_valid at T+1):
  - divisor=0: quotient = all ones; remainder = dividend.
  - signed overflow (DIV/REM, 0x80000000 / 0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- rd=0: request is accepted; unit returns to IDLE at T+1. o_valid is never asserted.
- i_flush: at any state -> IDLE at next edge; o_valid=0. Flush has priority over a same-cycle accept or a same-cycle writeback handshake.
- i_valid while busy: ignored. Upstream holds the request until o_ready.
- Output result register is cleared only by reset; its value is meaningful only while o_valid=1.

Optional Feature:
DIV_EARLY_OUT_EN:
- Defined: when operand magnitudes satisfy |rs1| < |rs2| (unsigned compare, divisor nonzero), take the fast path. Quotient = 0, remainder = original rs1 (sign preserved), o_valid at T+1.
- Undefined: such cases take the full 32-iteration path with identical results. Only latency differs.

Test Plan:
1. DIVU 100/7, rd=5 -> o_valid at T+33, o_rd_addr=5, o_rd_data=14. REMU same operands -> 2.
2. DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3). REM -> 0xFFFFFFFF (-1). DIV 7 / 0xFFFFFFFE -> 0xFFFFFFFD.
3. DIVU 5/0 -> 0xFFFFFFFF at T+1. REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1; REM -> 0.
4. Backpressure: hold i_wb_ready=0 for 5 cycles after result -> o_valid and o_rd_data stable, o_ready=0, new i_valid ignored. i_wb_ready=1 -> IDLE next cycle.
5. Abort and reset:
   - i_flush at T+10 -> o_valid never asserted; o_ready=1 at T+11.
   - i_rst low at T+20 -> all outputs 0 immediately, no result after release.
   - rd=0 request -> no o_valid; o_ready=1 at T+1.
6. DIVU 3/10 -> 0 with remainder 3. With DIV_EARLY_OUT_EN, latency is T+1; without it, T+33.

Source files
------------

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative RV32M divider (DIV/DIVU/REM/REMU), restoring, 1 bit per cycle.
// Optional DIV_EARLY_OUT_EN: |rs1| < |rs2| completes on the fast path.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic [4:0]      i_rd_addr,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_wb_ready,
    output logic [4:0]      o_rd_addr,
    output logic [XLEN-1:0] o_rd_data,
    output logic            o_busy
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, res_q, res_d;
    logic [4:0]      rd_q, rd_d;
    logic            is_rem_q, is_rem_d, neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;

    logic            is_signed, s1, s2, div_zero, ovf, early, fast;
    logic [XLEN-1:0] a_mag, b_mag, fast_quo, fast_rem;
    logic [XLEN:0]   trial, diff;
    logic            geq;
    logic [XLEN-1:0] rem_nx, quo_nx, quo_fin, rem_fin;

    // Operand decode for a request presented this cycle
    always_comb begin
        is_signed = ~i_op[0];
        s1        = is_signed & i_rs1_data[XLEN-1];
        s2        = is_signed & i_rs2_data[XLEN-1];
        a_mag     = s1 ? (~i_rs1_data + 1'b1) : i_rs1_data;
        b_mag     = s2 ? (~i_rs2_data + 1'b1) : i_rs2_data;
        div_zero  = (i_rs2_data == '0);
        ovf       = is_signed && (i_rs1_data == MIN_INT) && (i_rs2_data == '1);
`ifdef DIV_EARLY_OUT_EN
        early     = !div_zero && (a_mag < b_mag);
`else
        early     = 1'b0;
`endif
        fast      = div_zero | ovf | early;
        fast_quo  = div_zero ? '1 : (ovf ? MIN_INT : '0);
        fast_rem  = ovf ? '0 : i_rs1_data;
    end

    // One restoring step: shift {rem,quo} left, keep the difference when no borrow
    always_comb begin
        trial   = {rem_q, quo_q[XLEN-1]};
        diff    = trial - {1'b0, dvs_q};
        geq     = (trial >= {1'b0, dvs_q});
        rem_nx  = geq ? diff[XLEN-1:0] : trial[XLEN-1:0];
        quo_nx  = {quo_q[XLEN-2:0], geq};
        quo_fin = neg_quo_q ? (~quo_nx + 1'b1) : quo_nx;
        rem_fin = neg_rem_q ? (~rem_nx + 1'b1) : rem_nx;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        res_d     = res_q;
        rd_d      = rd_q;
        is_rem_d  = is_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        if (i_flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // rd=0 requests are consumed without ever producing a result
                    if (i_valid && (i_rd_addr != 5'd0)) begin
                        rd_d      = i_rd_addr;
                        is_rem_d  = i_op[1];
                        neg_quo_d = s1 ^ s2;
                        neg_rem_d = s1;
                        if (fast) begin
                            res_d   = i_op[1] ? fast_rem : fast_quo;
                            state_d = S_DONE;
                        end else begin
                            rem_d   = '0;
                            quo_d   = a_mag;
                            dvs_d   = b_mag;
                            cnt_d   = '0;
                            state_d = S_DIV;
                        end
                    end
                end
                S_DIV: begin
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(XLEN-1)) begin
                        res_d   = is_rem_q ? rem_fin : quo_fin;
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_wb_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            res_q     <= '0;
            rd_q      <= '0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            res_q     <= res_d;
            rd_q      <= rd_d;
            is_rem_q  <= is_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    // o_ready is held low while reset is asserted so every output reads 0
    assign o_ready   = (state_q == S_IDLE) & i_rst;
    assign o_valid   = (state_q == S_DONE);
    assign o_busy    = (state_q != S_IDLE);
    assign o_rd_addr = rd_q;
    assign o_rd_data = res_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit with a result scoreboard.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        i_rst, i_valid, o_ready, i_flush, o_valid, i_wb_ready, o_busy;
    logic [1:0]  i_op;
    logic [31:0] i_rs1_data, i_rs2_data, o_rd_data;
    logic [4:0]  i_rd_addr, o_rd_addr;

    always #5 clk = ~clk;

    div_unit #(.XLEN(32)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready), .i_op(i_op),
        .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_rd_addr(i_rd_addr),
        .i_flush(i_flush), .o_valid(o_valid), .i_wb_ready(i_wb_ready),
        .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data), .o_busy(o_busy)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        got_v;
    logic [31:0] got_d;
    logic [4:0]  got_a;
    int          got_lat;

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb_;
        sa  = a;
        sb_ = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            2'b00:   return sa / sb_;
            2'b01:   return a / b;
            2'b10:   return sa % sb_;
            default: return a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb;
        ma = (!op[0] && a[31]) ? (32'd0 - a) : a;
        mb = (!op[0] && b[31]) ? (32'd0 - b) : b;
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_OUT_EN
        if (ma < mb) return 1;
`else
        if (ma < mb) return 33;
`endif
        return 33;
    endfunction

    // Drive one request so it is accepted at the next edge; returns #1 after that edge
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        exp_t e;
        i_op = op; i_rs1_data = a; i_rs2_data = b; i_rd_addr = rd; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        if (rd != 5'd0) begin
            e.rd = rd; e.data = model(op, a, b); e.lat = model_lat(op, a, b);
            sb.push_back(e);
        end
    endtask

    task automatic wait_result();
        got_v = 1'b0; got_d = '0; got_a = '0; got_lat = 1;
        while (got_lat <= 60) begin
            if (o_valid) begin
                got_v = 1'b1; got_d = o_rd_data; got_a = o_rd_addr;
                break;
            end
            @(posedge clk); #1;
            got_lat++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({o_valid, o_ready, o_busy, o_rd_addr, o_rd_data} !== 39'd0) begin
            n_fail++; $display("FAIL reset_outputs: got v=%b r=%b b=%b a=%0d d=%h, expected all 0", o_valid, o_ready, o_busy, o_rd_addr, o_rd_data);
        end
        i_rst = 1'b1;
        #1;
        n_checks++;
        if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: got ready=%b busy=%b, expected 1 0", o_ready, o_busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [1:0]  ops[4] = '{2'b01, 2'b11, 2'b01, 2'b11};
        logic [31:0] as[4]  = '{32'd100, 32'd100, 32'hFFFF_FFFF, 32'd1000};
        logic [31:0] bs[4]  = '{32'd7, 32'd7, 32'd1, 32'd3};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i], 5'd5 + 5'(i));
            wait_result();
            e = sb.pop_front();
            n_checks++;
            if (!got_v) begin n_fail++; $display("FAIL basic_timeout[%0d]: no o_valid, expected one", i); end
            else begin
                n_checks += 2;
                if (got_d !== e.data || got_a !== e.rd) begin n_fail++; $display("FAIL basic_result[%0d]: got rd=%0d d=%h expected rd=%0d d=%h", i, got_a, got_d, e.rd, e.data); end
                if (got_lat != e.lat) begin n_fail++; $display("FAIL basic_latency[%0d]: got %0d expected %0d", i, got_lat, e.lat); end
            end
            @(posedge clk); #1;
            n_checks++;
            if (o_ready !== 1'b1 || o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle[%0d]: got ready=%b valid=%b expected 1 0", i, o_ready, o_valid); end
        end
    endtask

    task automatic test_signed();
        logic [1:0]  ops[4] = '{2'b00, 2'b10, 2'b00, 2'b10};
        logic [31:0] as[4]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7};
        logic [31:0] bs[4]  = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
        logic [31:0] want[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i], 5'd10);
            wait_result();
            e = sb.pop_front();
            n_checks++;
            if (!got_v || got_d !== want[i] || got_d !== e.data) begin
                n_fail++; $display("FAIL signed[%0d]: got valid=%b d=%h expected %h", i, got_v, got_d, want[i]);
            end
            n_checks++;
            if (got_lat != e.lat) begin n_fail++; $display("FAIL signed_latency[%0d]: got %0d expected %0d", i, got_lat, e.lat); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_special();
        logic [1:0]  ops[4] = '{2'b01, 2'b11, 2'b00, 2'b10};
        logic [31:0] as[4]  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs[4]  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] want[4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i], 5'd20 + 5'(i));
            wait_result();
            e = sb.pop_front();
            n_checks++;
            if (!got_v || got_d !== want[i] || got_a !== e.rd) begin
                n_fail++; $display("FAIL special[%0d]: got valid=%b rd=%0d d=%h expected rd=%0d d=%h", i, got_v, got_a, got_d, e.rd, want[i]);
            end
            n_checks++;
            if (got_lat != 1) begin n_fail++; $display("FAIL special_latency[%0d]: got %0d expected 1", i, got_lat); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_early_out();
        exp_t e;
        int   want_lat;
`ifdef DIV_EARLY_OUT_EN
        want_lat = 1;
`else
        want_lat = 33;
`endif
        for (int i = 0; i < 2; i++) begin
            issue(i == 0 ? 2'b01 : 2'b11, 32'd3, 32'd10, 5'd12);
            wait_result();
            e = sb.pop_front();
            n_checks += 2;
            if (!got_v || got_d !== (i == 0 ? 32'd0 : 32'd3)) begin n_fail++; $display("FAIL early_result[%0d]: got valid=%b d=%h expected %h", i, got_v, got_d, e.data); end
            if (got_lat != want_lat) begin n_fail++; $display("FAIL early_latency[%0d]: got %0d expected %0d", i, got_lat, want_lat); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        i_wb_ready = 1'b0;
        issue(2'b01, 32'd1000, 32'd9, 5'd7);
        wait_result();
        e = sb.pop_front();
        n_checks++;
        if (!got_v || got_d !== e.data) begin n_fail++; $display("FAIL bp_result: got valid=%b d=%h expected %h", got_v, got_d, e.data); end
        for (int k = 0; k < 5; k++) begin
            i_op = 2'b01; i_rs1_data = 32'd77; i_rs2_data = 32'd0; i_rd_addr = 5'd9; i_valid = 1'b1;
            @(posedge clk); #1;
            n_checks++;
            if ({o_valid, o_ready, o_rd_addr, o_rd_data} !== {1'b1, 1'b0, e.rd, e.data}) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got v=%b r=%b rd=%0d d=%h expected v=1 r=0 rd=%0d d=%h", k, o_valid, o_ready, o_rd_addr, o_rd_data, e.rd, e.data);
            end
        end
        i_valid = 1'b0;
        i_wb_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got valid=%b ready=%b expected 0 1", o_valid, o_ready); end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL bp_ignored: got valid=%b busy=%b expected 0 0", o_valid, o_busy); end
    endtask

    task automatic test_flush();
        int seen;
        issue(2'b01, 32'd12345, 32'd67, 5'd3);
        sb.delete();
        repeat (9) @(posedge clk);
        #1;
        i_flush = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0;
        n_checks++;
        if (o_ready !== 1'b1 || o_busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle: got ready=%b busy=%b expected 1 0", o_ready, o_busy); end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (o_valid) seen++;
        end
        n_checks++;
        if (seen != 0) begin n_fail++; $display("FAIL flush_no_result: got %0d valid cycles expected 0", seen); end
        i_op = 2'b01; i_rs1_data = 32'd9; i_rs2_data = 32'd0; i_rd_addr = 5'd4; i_valid = 1'b1; i_flush = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0; i_flush = 1'b0;
        n_checks++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0) begin n_fail++; $display("FAIL flush_over_accept: got busy=%b valid=%b expected 0 0", o_busy, o_valid); end
    endtask

    task automatic test_reset_mid();
        int seen;
        issue(2'b00, 32'hFFFF_FF9C, 32'd3, 5'd4);
        sb.delete();
        repeat (19) @(posedge clk);
        #2;
        i_rst = 1'b0;
        #1;
        n_checks++;
        if ({o_valid, o_ready, o_busy, o_rd_addr, o_rd_data} !== 39'd0) begin
            n_fail++; $display("FAIL reset_mid_outputs: got v=%b r=%b b=%b a=%0d d=%h expected all 0", o_valid, o_ready, o_busy, o_rd_addr, o_rd_data);
        end
        @(posedge clk); #1;
        i_rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (o_valid) seen++;
        end
        n_checks++;
        if (seen != 0 || o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mid_no_result: got %0d valid cycles ready=%b expected 0 1", seen, o_ready); end
    endtask

    task automatic test_rd_zero();
        int seen;
        issue(2'b01, 32'd50, 32'd5, 5'd0);
        n_checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL rd0_idle: got valid=%b ready=%b busy=%b expected 0 1 0", o_valid, o_ready, o_busy);
        end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (o_valid) seen++;
        end
        n_checks++;
        if (seen != 0) begin n_fail++; $display("FAIL rd0_no_result: got %0d valid cycles expected 0", seen); end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [1:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 10; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (i % 4 == 1) b = b >> $urandom_range(0, 31);
            issue(op, a, b, 5'($urandom_range(1, 31)));
            wait_result();
            e = sb.pop_front();
            n_checks += 2;
            if (!got_v || got_d !== e.data || got_a !== e.rd) begin
                n_fail++; $display("FAIL b2b_result[%0d] op=%0d a=%h b=%h: got valid=%b rd=%0d d=%h expected rd=%0d d=%h", i, op, a, b, got_v, got_a, got_d, e.rd, e.data);
            end
            if (got_lat != e.lat) begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", i, got_lat, e.lat); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        i_rst = 1'b0; i_valid = 1'b0; i_op = 2'b00; i_rs1_data = '0; i_rs2_data = '0;
        i_rd_addr = '0; i_flush = 1'b0; i_wb_ready = 1'b1;
        test_reset();
        test_basic();
        test_signed();
        test_special();
        test_early_out();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_rd_zero();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
